linear_network_multicast_ctrl: RTL and testbench

Round-robin scheduler that shares one `linear_network_multicast_comb` chain between `NUM_REQ` requesters. Each requester offers a data word plus a multi-hot destination mask. The block arbitrates among them, registers the winner into a one-entry issue stage, and drives the chain's `i_valid` / `i_data_bus` / `i_en` / `i_cmd`. It holds each transaction until every addressed node is ready, then retires it. It sits directly in front of the linear network, one instance per chain.

---
 rtl/linear_network_multicast_ctrl.sv | 107 ++++++++++
 tb/tb_linear_network_multicast_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_network_multicast_ctrl.sv
// Round-robin issue controller for one linear_network_multicast_comb chain.
// A single held transaction is stalled until every addressed node is ready, then retired.
module linear_network_multicast_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4,
    parameter int NUM_REQ    = 4,
    parameter int REQ_ID_W   = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ*NUM_NODE-1:0]  i_req_dest,
    output logic [NUM_REQ-1:0]           o_req_ready,
    input  logic [NUM_NODE-1:0]          i_node_ready,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data_bus,
    output logic                         o_en,
    output logic [NUM_NODE-1:0]          o_cmd,
    output logic [REQ_ID_W-1:0]          o_grant_id,
    output logic                         o_busy
);

    // state | meaning
    // EMPTY | no transaction held, chain idle
    // HOLD  | {data_q, dest_q, id_q} driven on the chain until all addressed nodes ready
    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NUM_NODE-1:0]   dest_q;
    logic [REQ_ID_W-1:0]   id_q;
    logic [REQ_ID_W-1:0]   rr_ptr;

    logic                  found;
    logic [REQ_ID_W-1:0]   winner;
    logic [REQ_ID_W-1:0]   idx;
    logic [REQ_ID_W-1:0]   next_ptr;
    logic                  retire;
    logic                  slot_free;
    logic                  accept;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_NODE-1:0]   win_dest;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = REQ_ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && i_req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Unaddressed nodes are masked so they never block delivery.
    assign o_en      = (state == HOLD) & (&(i_node_ready | ~dest_q));
    assign retire    = o_en;
    assign slot_free = (state == EMPTY) | retire;
    // rst_n gate keeps the handshake closed while reset is held.
    assign accept    = found & slot_free & rst_n;
    assign win_data  = i_req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    assign win_dest  = i_req_dest[int'(winner)*NUM_NODE +: NUM_NODE];
    assign next_ptr  = (winner == REQ_ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        o_req_ready = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            o_req_ready[r] = accept && (winner == REQ_ID_W'(r));
        end
    end

    // Zero-mask requests complete the handshake but never enter HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            data_q <= '0;
            dest_q <= '0;
            id_q   <= '0;
            rr_ptr <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= next_ptr;
            end
            if (accept && (|win_dest)) begin
                state  <= HOLD;
                data_q <= win_data;
                dest_q <= win_dest;
                id_q   <= winner;
            end else if (retire) begin
                state  <= EMPTY;
                data_q <= '0;
                dest_q <= '0;
                id_q   <= '0;
            end
        end
    end

    assign o_valid    = (state == HOLD);
    assign o_busy     = (state == HOLD);
    assign o_data_bus = data_q;
    assign o_cmd      = dest_q;
    assign o_grant_id = id_q;

endmodule

// File: tb/tb_linear_network_multicast_ctrl.sv
// Self-checking bench for linear_network_multicast_ctrl: a scoreboard queue holds
// accepted transactions and is popped when the chain strobe o_en delivers them.
module tb_linear_network_multicast_ctrl;

    localparam int DW = 32;
    localparam int NN = 4;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR*NN-1:0] req_dest;
    logic [NR-1:0] req_ready;
    logic [NN-1:0] node_ready;
    logic          valid;
    logic [DW-1:0] data_bus;
    logic          en;
    logic [NN-1:0] cmd;
    logic [1:0]    grant_id;
    logic          busy;

    always #5 clk = ~clk;

    linear_network_multicast_ctrl #(.DATA_WIDTH(DW), .NUM_NODE(NN), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_data(req_data), .i_req_dest(req_dest),
        .o_req_ready(req_ready), .i_node_ready(node_ready),
        .o_valid(valid), .o_data_bus(data_bus), .o_en(en), .o_cmd(cmd),
        .o_grant_id(grant_id), .o_busy(busy)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [3:0]  dest;
    } txn_t;

    txn_t sb[$];
    int   m_rr;
    int   errors = 0;
    int   checks = 0;

    function automatic int m_win();
        for (int i = 0; i < NR; i++) begin
            if (req_valid[(m_rr + i) % NR]) return (m_rr + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic m_en();
        if (sb.size() == 0) return 1'b0;
        return &(node_ready | ~sb[0].dest);
    endfunction

    function automatic logic [3:0] m_ready();
        int w;
        w = m_win();
        if (w < 0) return 4'b0000;
        if (sb.size() == 0 || m_en()) return 4'(1 << w);
        return 4'b0000;
    endfunction

    // Advance the reference model across the coming rising edge.
    task automatic model_edge();
        logic       e;
        logic [3:0] r;
        int         w;
        txn_t       t;
        e = m_en();
        r = m_ready();
        w = m_win();
        if (e) void'(sb.pop_front());
        if (r != 4'b0000) begin
            m_rr = (w + 1) % NR;
            if (req_dest[w*NN +: NN] != 4'b0000) begin
                t.id   = w;
                t.data = req_data[w*DW +: DW];
                t.dest = req_dest[w*NN +: NN];
                sb.push_back(t);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        sb.delete();
        m_rr = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        req_dest   = 16'hFFFF;
        node_ready = 4'b1111;
        sb.delete();
        m_rr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b exp 0000", req_ready); end
        checks++; if ({valid, en, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {valid, en, busy}); end
        checks++; if ({data_bus, cmd, grant_id} !== '0) begin errors++; $display("FAIL rst_bus: got %h/%b/%0d exp zero", data_bus, cmd, grant_id); end
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        repeat (2) begin
            tick();
            @(negedge clk);
            checks++; if (valid !== 1'b0 || data_bus !== 32'h0) begin errors++; $display("FAIL idle: got valid=%b data=%h exp 0/0", valid, data_bus); end
            model_edge();
        end
        tick();
    endtask

    task automatic test_unicast();
        node_ready = 4'b1111;
        req_data[2*DW +: DW] = 32'hAAAAAAAA;
        req_dest[2*NN +: NN] = 4'b0001;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL uni_ready: got %b exp 0100", req_ready); end
        model_edge();
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (valid !== 1'b1 || en !== m_en()) begin errors++; $display("FAIL uni_strobe: got valid=%b en=%b exp 1/%b", valid, en, m_en()); end
        checks++; if (cmd !== 4'b0001 || grant_id !== 2'd2) begin errors++; $display("FAIL uni_cmd: got %b/%0d exp 0001/2", cmd, grant_id); end
        checks++; if (data_bus !== sb[0].data) begin errors++; $display("FAIL uni_data: got %h exp %h", data_bus, sb[0].data); end
        model_edge();
        tick();
        @(negedge clk);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL uni_empty: got valid=%b busy=%b exp 0/0", valid, busy); end
        model_edge();
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        node_ready = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            req_valid = 4'b1111;
            for (int r = 0; r < NR; r++) begin
                req_data[r*DW +: DW] = 32'h5A000000 ^ 32'(c * 16 + r);
                req_dest[r*NN +: NN] = 4'((r + c) % 15 + 1);
            end
            @(negedge clk);
            checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", c, req_ready, 4'(1 << (c % 4))); end
            checks++; if (en !== (c > 0)) begin errors++; $display("FAIL rr_en[%0d]: got %b exp %b", c, en, (c > 0)); end
            if (c > 0) begin
                checks++;
                if (grant_id !== 2'(sb[0].id) || data_bus !== sb[0].data || cmd !== sb[0].dest) begin
                    errors++;
                    $display("FAIL rr_txn[%0d]: got id=%0d data=%h cmd=%b exp id=%0d data=%h cmd=%b",
                             c, grant_id, data_bus, cmd, sb[0].id, sb[0].data, sb[0].dest);
                end
            end
            model_edge();
            tick();
        end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (en !== 1'b1 || grant_id !== 2'(sb[0].id) || data_bus !== sb[0].data) begin errors++; $display("FAIL rr_drain: got en=%b id=%0d data=%h exp 1/%0d/%h", en, grant_id, data_bus, sb[0].id, sb[0].data); end
        model_edge();
        tick();
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got valid=%b exp 0", valid); end
        model_edge();
        tick();
    endtask

    task automatic test_stall();
        node_ready = 4'b1111;
        req_data[0*DW +: DW] = 32'hBBBBBBBB;
        req_dest[0*NN +: NN] = 4'b1110;
        req_data[1*DW +: DW] = 32'h11112222;
        req_dest[1*NN +: NN] = 4'b0011;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL st_accept: got %b exp 0001", req_ready); end
        model_edge();
        tick();
        for (int k = 0; k < 3; k++) begin
            req_valid  = 4'b0010;
            node_ready = 4'b1011;
            @(negedge clk);
            checks++; if (valid !== 1'b1 || en !== 1'b0) begin errors++; $display("FAIL st_hold[%0d]: got valid=%b en=%b exp 1/0", k, valid, en); end
            checks++; if (data_bus !== 32'hBBBBBBBB || cmd !== 4'b1110) begin errors++; $display("FAIL st_stable[%0d]: got %h/%b exp bbbbbbbb/1110", k, data_bus, cmd); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL st_block[%0d]: got %b exp 0000", k, req_ready); end
            model_edge();
            tick();
        end
        node_ready = 4'b1111;
        @(negedge clk);
        checks++; if (en !== 1'b1 || data_bus !== sb[0].data) begin errors++; $display("FAIL st_release: got en=%b data=%h exp 1/%h", en, data_bus, sb[0].data); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL st_b2b: got %b exp 0010", req_ready); end
        model_edge();
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (en !== 1'b1 || grant_id !== 2'(sb[0].id) || cmd !== sb[0].dest || data_bus !== sb[0].data) begin errors++; $display("FAIL st_next: got en=%b id=%0d cmd=%b data=%h exp 1/%0d/%b/%h", en, grant_id, cmd, data_bus, sb[0].id, sb[0].dest, sb[0].data); end
        model_edge();
        tick();
    endtask

    task automatic test_zero_mask();
        apply_reset();
        node_ready = 4'b1111;
        req_data[1*DW +: DW] = 32'hDEADBEEF;
        req_dest[1*NN +: NN] = 4'b0000;
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL zm_handshake: got %b exp 0010", req_ready); end
        model_edge();
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zm_drop: got valid=%b busy=%b exp 0/0", valid, busy); end
        model_edge();
        tick();
        req_data[2*DW +: DW] = 32'h0F0F0F0F;
        req_dest[2*NN +: NN] = 4'b1000;
        req_valid = 4'b0110;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL zm_ptr: got %b exp 0100", req_ready); end
        model_edge();
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (en !== 1'b1 || grant_id !== 2'(sb[0].id) || data_bus !== sb[0].data) begin errors++; $display("FAIL zm_deliver: got en=%b id=%0d data=%h exp 1/%0d/%h", en, grant_id, data_bus, sb[0].id, sb[0].data); end
        model_edge();
        tick();
    endtask

    task automatic test_reset_mid();
        node_ready = 4'b1111;
        req_data[3*DW +: DW] = 32'hCCCCCCCC;
        req_dest[3*NN +: NN] = 4'b0100;
        req_valid = 4'b1000;
        @(negedge clk);
        model_edge();
        tick();
        req_valid  = 4'b1010;
        node_ready = 4'b1011;
        @(negedge clk);
        checks++; if (valid !== 1'b1 || en !== 1'b0) begin errors++; $display("FAIL rm_stall: got valid=%b en=%b exp 1/0", valid, en); end
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_rr = 0;
        #1;
        checks++; if ({valid, busy, en} !== 3'b000 || cmd !== 4'b0000 || data_bus !== 32'h0) begin errors++; $display("FAIL rm_async: got v/b/e=%b cmd=%b data=%h exp zero", {valid, busy, en}, cmd, data_bus); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready: got %b exp 0000", req_ready); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        node_ready = 4'b1111;
        req_data[1*DW +: DW] = 32'h77777777;
        req_dest[1*NN +: NN] = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_first: got %b exp 0010", req_ready); end
        model_edge();
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (en !== 1'b1 || grant_id !== 2'(sb[0].id) || data_bus !== sb[0].data) begin errors++; $display("FAIL rm_nodeliver: got en=%b id=%0d data=%h exp 1/%0d/%h", en, grant_id, data_bus, sb[0].id, sb[0].data); end
        model_edge();
        tick();
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rm_idle: got valid=%b exp 0", valid); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_round_robin();
        test_stall();
        test_zero_mask();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
